// File: rtl/rptr_empty_fwft.sv
// Read-side pointer, synchronized empty flag and one-entry FWFT output
// register for the async FIFO, clocked by rclk.
module rptr_empty_fwft #(
    parameter int AddrWidth = 4,
    parameter int DataWidth = 8
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 aempty_n,
    input  logic [DataWidth-1:0] mem_rdata_i,
    input  logic                 rready_i,
    output logic [AddrWidth-1:0] raddr_o,
    output logic [AddrWidth-1:0] rptr_o,
    output logic                 mem_ren_o,
    output logic                 rempty_o,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o
);

    logic [AddrWidth-1:0] r_bin;
    logic [AddrWidth-1:0] r_gray;
    logic                 r_rempty;
    logic                 r_rempty2;
    logic                 r_rvalid;
    logic [DataWidth-1:0] r_rdata;

    logic                 w_rempty;
    logic                 w_fetch;
    logic [AddrWidth-1:0] w_bnext;
    logic [AddrWidth-1:0] w_gnext;

    // Assert immediately on the raw input, release only after two edges.
    assign w_rempty = r_rempty | ~aempty_n;
    assign w_fetch  = ~w_rempty & (~r_rvalid | rready_i);
    assign w_bnext  = r_bin + AddrWidth'(w_fetch);
    assign w_gnext  = (w_bnext >> 1) ^ w_bnext;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_bin     <= '0;
            r_gray    <= '0;
            r_rempty  <= 1'b1;
            r_rempty2 <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_bin  <= w_bnext;
            r_gray <= w_gnext;
            if (!aempty_n) begin
                r_rempty  <= 1'b1;
                r_rempty2 <= 1'b1;
            end else begin
                r_rempty  <= r_rempty2;
                r_rempty2 <= 1'b0;
            end
            if (w_fetch) begin
                r_rdata  <= mem_rdata_i;
                r_rvalid <= 1'b1;
            end else if (r_rvalid && rready_i) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign raddr_o   = r_bin;
    assign rptr_o    = r_gray;
    assign mem_ren_o = w_fetch;
    assign rempty_o  = w_rempty;
    assign rvalid_o  = r_rvalid;
    assign rdata_o   = r_rdata;

endmodule

// File: doc/rptr_empty_fwft.md
Name: rptr_empty_fwft

Overview:
Read-side pointer and empty-flag logic for the async FIFO, clocked by rclk. It is the read-domain counterpart of the write pointer/full block. It keeps the binary read address and the registered Gray read pointer, and filters the asynchronous-comparison almost-empty input (aempty_n) into a safe empty flag. It adds a one-entry first-word-fall-through (FWFT) output register with a valid/ready handshake toward the consumer.

Parameters:
AddrWidth, 4, memory address width; depth = 2**AddrWidth; pointers are AddrWidth bits (no wrap bit, direction handled by the comparator)
DataWidth, 8, width of FIFO word

Ports:
rclk  input  1  read clock
rrst  input  1  synchronous active-high reset
aempty_n  input  1  async-comparison "going empty" from pointer comparator, active low, asynchronous to rclk
mem_rdata_i  input  DataWidth  FIFO memory read data, combinational function of raddr_o
rready_i  input  1  consumer accepts rdata_o this cycle
raddr_o  output  AddrWidth  binary read address to memory
rptr_o  output  AddrWidth  registered Gray read pointer to comparator
mem_ren_o  output  1  fetch strobe: memory word at raddr_o consumed this cycle
rempty_o  output  1  FIFO memory empty (excludes word held in output register)
rvalid_o  output  1  rdata_o holds a valid word
rdata_o  output  DataWidth  FWFT output data

Behaviour:
- All state updates occur only on posedge rclk; there are no asynchronous set/clear paths.
- Reset (rrst=1 at an edge): rbin=0, rptr=0, {rempty,rempty2}=2'b11, rvalid=0, rdata=0. Reset wins over every other event.
- Empty flag pair:
  - If aempty_n=0 at an edge: {rempty,rempty2} <= 2'b11.
  - Otherwise: {rempty,rempty2} <= {rempty2, 1'b0}. Deassertion therefore takes 2 edges of aempty_n held high.
  - rempty_o = rempty | ~aempty_n. Assertion is combinational in the same cycle, deassertion is synchronized. This is the only combinational path from an asynchronous input.
- fetch = ~rempty_o & (~rvalid | rready_i); mem_ren_o = fetch.
- Pointer update:
  - rbnext = rbin + fetch, modulo 2**AddrWidth, wrapping 2**AddrWidth-1 -> 0.
  - rgnext = (rbnext>>1) ^ rbnext.
  - Each edge: rbin <= rbnext, rptr <= rgnext.
  - raddr_o = rbin; rptr_o = rptr (registered, glitch-free Gray, one bit changes per increment).
- Output register:
  - fetch: rdata <= mem_rdata_i (word at the old raddr_o), rvalid <= 1.
  - else if rvalid & rready_i: rvalid <= 0.
  - else hold.
- Handshake: a transfer occurs when rvalid_o & rready_i at an edge. rdata_o and rvalid_o are stable while rvalid_o=1 and rready_i=0.
- Throughput: one word per cycle with rready_i held high and FIFO non-empty.
- Latency: 1 edge from fetch to rvalid_o.
- Simultaneous events:
  - Consume and fetch in the same cycle replace the word; rvalid stays 1.
  - If aempty_n falls in the cycle a fetch would occur, no fetch happens (rempty_o=1 blocks it). Overread is impossible.
- rempty_o=1 with rvalid_o=1 is legal: the last word is still held in the output register.
- Reset mid-operation discards the held word. The pointer returns to 0; the write side must be reset coherently.

Test Plan:
- Reset with aempty_n=1: after rrst drops, raddr_o=0, rptr_o=0, rvalid_o=0, rempty_o=1 for 2 edges, then 0. The first fetch occurs on the 3rd edge, mem_ren_o=1 in that cycle.
- Streaming, mem_rdata_i=8'hA0+raddr_o, rready_i=1:
  - rdata_o sequence A0,A1,A2,A3, one per cycle.
  - rptr_o sequence 0,1,3,2,6.
- Wrap: 17 consecutive fetches. raddr_o goes 15 -> 0 with rptr_o 4'b1000 -> 4'b0000, and rdata_o shows AF then A0.
- Backpressure: rvalid_o=1, rdata_o=A2, rready_i=0 for 5 cycles. rdata_o holds A2, raddr_o stays 3, mem_ren_o=0. Then rready_i=1 gives A3 on the next edge.
- Empty race: aempty_n=0 for 1 cycle mid-stream.
  - rempty_o=1 in that same cycle and mem_ren_o=0.
  - After aempty_n returns to 1, exactly 2 edges pass before the next fetch.
  - The held word is not lost.
- Synchronous reset mid-stream at raddr_o=5, rvalid_o=1: outputs are unchanged until the edge, then raddr_o=0, rptr_o=0, rvalid_o=0, rempty_o=1.
